// File: rtl/order_pkg.sv
// -----------------------------------------------------------------------------
// order_pkg
// Shared types and defaults for the order generator slice.
//   og_state_t : order FSM states (IDLE -> ISSUE -> COOLDOWN -> IDLE)
//   side_t     : order side encoding (0 = buy, 1 = sell)
//   *_DEF      : default parameter values used by order_gen
//   sat_inc16  : saturating 16-bit increment used by the optional statistics
// -----------------------------------------------------------------------------
package order_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      ISSUE    = 2'd1,
      COOLDOWN = 2'd2
   } og_state_t;

   typedef enum logic {
      SIDE_BUY  = 1'b0,
      SIDE_SELL = 1'b1
   } side_t;

   localparam logic [7:0]  LOT_SIZE_DEF        = 8'd10;
   localparam logic [15:0] MAX_POS_DEF         = 16'd100;
   localparam logic [7:0]  COOLDOWN_CYCLES_DEF = 8'd16;
   localparam int          POS_W_DEF           = 16;

   // Increment that sticks at all-ones instead of wrapping to zero.
   function automatic logic [15:0] sat_inc16(input logic [15:0] value);
      logic [15:0] result;
      if (value == 16'hFFFF) begin
         result = value;
      end else begin
         result = value + 16'd1;
      end
      return result;
   endfunction

endpackage

// File: rtl/order_cooldown.sv
// -----------------------------------------------------------------------------
// order_cooldown
// Loadable down-counter that times the post-order cooldown window.
// A load writes load_value; afterwards the count drops by one each cycle and
// rests at zero. done flags the last cooldown cycle (count == 1), so a load of
// N keeps the owning FSM in its cooldown state for exactly N cycles.
// Ports:
//   clk        in  1      system clock, rising edge
//   rst        in  1      asynchronous reset, active-high
//   load       in  1      load load_value into the counter
//   load_value in  CNT_W  cooldown length in cycles
//   done       out 1      counter is on its final cooldown cycle
// -----------------------------------------------------------------------------
module order_cooldown #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [CNT_W-1:0] load_value,
   output logic             done
);

   logic [CNT_W-1:0] count_r;

   // Down-counter: load has priority, then decrement until zero.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_r <= {CNT_W{1'b0}};
      end else if (load) begin
         count_r <= load_value;
      end else if (count_r != {CNT_W{1'b0}}) begin
         count_r <= count_r - CNT_W'(1);
      end else begin
         count_r <= count_r;
      end
   end

   // Terminal flag: the cycle in which count reads one is the last one.
   always_comb begin
      done = (count_r == CNT_W'(1));
   end

endmodule

// File: rtl/order_gen.sv
// -----------------------------------------------------------------------------
// order_gen
// Turns the trade logic unit's registered buy/sell decision into a single
// order transaction on a valid/ready handshake, tracks the signed net position
// under a symmetric limit and enforces a cooldown after every accepted order.
// All outputs are registered.
//
// Optional feature macro: ORDER_STATS_EN adds saturating buy/sell/drop counters.
//
// Ports:
//   clk          in  1      system clock, rising edge
//   rst          in  1      asynchronous reset, active-high
//   enable       in  1      1 = new orders allowed (an in-flight order still completes)
//   buy_signal   in  1      buy decision, qualified by signal_valid
//   sell_signal  in  1      sell decision, qualified by signal_valid
//   signal_valid in  1      decision valid this cycle
//   price_in     in  8      market price aligned with signal_valid
//   order_ready  in  1      downstream accepts the order this cycle
//   order_valid  out 1      order presented
//   order_side   out 1      0 = buy, 1 = sell
//   order_qty    out 8      LOT_SIZE while order_valid, else 0
//   order_price  out 8      price captured when the decision was accepted
//   position     out POS_W  signed net position
//   busy         out 1      high while in ISSUE or COOLDOWN
//   buy_count    out 16     (ORDER_STATS_EN) completed buy orders, saturating
//   sell_count   out 16     (ORDER_STATS_EN) completed sell orders, saturating
//   drop_count   out 16     (ORDER_STATS_EN) decisions not accepted, saturating
// -----------------------------------------------------------------------------
module order_gen
   import order_pkg::*;
#(
   parameter logic [7:0]  LOT_SIZE        = LOT_SIZE_DEF,
   parameter logic [15:0] MAX_POS         = MAX_POS_DEF,
   parameter logic [7:0]  COOLDOWN_CYCLES = COOLDOWN_CYCLES_DEF,
   parameter int          POS_W           = POS_W_DEF
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    enable,
   input  logic                    buy_signal,
   input  logic                    sell_signal,
   input  logic                    signal_valid,
   input  logic [7:0]              price_in,
   input  logic                    order_ready,
   output logic                    order_valid,
   output logic                    order_side,
   output logic [7:0]              order_qty,
   output logic [7:0]              order_price,
   output logic signed [POS_W-1:0] position,
   output logic                    busy
`ifdef ORDER_STATS_EN
   ,
   output logic [15:0]             buy_count,
   output logic [15:0]             sell_count,
   output logic [15:0]             drop_count
`endif
);

   og_state_t state_r;
   og_state_t next_state_s;
   side_t     side_s;
   logic      buy_req_s;
   logic      sell_req_s;
   logic      accept_s;
   logic      handshake_s;
   logic      cd_load_s;
   logic      cd_done_s;

   // One extra bit of headroom so the limit compare cannot overflow.
   logic signed [POS_W:0] pos_ext_s;
   logic signed [POS_W:0] lot_ext_s;
   logic signed [POS_W:0] max_ext_s;
   logic signed [POS_W:0] pos_plus_s;
   logic signed [POS_W:0] pos_minus_s;
   logic                  buy_ok_s;
   logic                  sell_ok_s;

   order_cooldown #(
      .CNT_W (8)
   ) u_cooldown (
      .clk        (clk),
      .rst        (rst),
      .load       (cd_load_s),
      .load_value (COOLDOWN_CYCLES),
      .done       (cd_done_s)
   );

   // Decision qualification and position limit arithmetic.
   always_comb begin
      buy_req_s   = signal_valid & enable & buy_signal & ~sell_signal;
      sell_req_s  = signal_valid & enable & sell_signal & ~buy_signal;
      handshake_s = order_valid & order_ready;
      pos_ext_s   = {position[POS_W-1], position};
      lot_ext_s   = (POS_W+1)'(LOT_SIZE);
      max_ext_s   = (POS_W+1)'(MAX_POS);
      pos_plus_s  = pos_ext_s + lot_ext_s;
      pos_minus_s = pos_ext_s - lot_ext_s;
      buy_ok_s    = (pos_plus_s <= max_ext_s);
      sell_ok_s   = (pos_minus_s >= -max_ext_s);
   end

   // Next-state logic; decisions outside IDLE are simply not accepted.
   always_comb begin
      next_state_s = state_r;
      accept_s     = 1'b0;
      side_s       = SIDE_BUY;
      cd_load_s    = 1'b0;
      case (state_r)
         IDLE: begin
            if (buy_req_s && buy_ok_s) begin
               accept_s     = 1'b1;
               side_s       = SIDE_BUY;
               next_state_s = ISSUE;
            end else if (sell_req_s && sell_ok_s) begin
               accept_s     = 1'b1;
               side_s       = SIDE_SELL;
               next_state_s = ISSUE;
            end else begin
               next_state_s = IDLE;
            end
         end
         ISSUE: begin
            if (handshake_s) begin
               if (COOLDOWN_CYCLES == 8'd0) begin
                  next_state_s = IDLE;
               end else begin
                  next_state_s = COOLDOWN;
                  cd_load_s    = 1'b1;
               end
            end else begin
               next_state_s = ISSUE;
            end
         end
         COOLDOWN: begin
            if (cd_done_s) begin
               next_state_s = IDLE;
            end else begin
               next_state_s = COOLDOWN;
            end
         end
         default: begin
            next_state_s = IDLE;
         end
      endcase
   end

   // State, order outputs and position register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r     <= IDLE;
         order_valid <= 1'b0;
         order_side  <= 1'b0;
         order_qty   <= 8'd0;
         order_price <= 8'd0;
         position    <= {POS_W{1'b0}};
         busy        <= 1'b0;
      end else begin
         state_r <= next_state_s;
         busy    <= (next_state_s != IDLE);
         if (accept_s) begin
            order_valid <= 1'b1;
            order_side  <= side_s;
            order_qty   <= LOT_SIZE;
            order_price <= price_in;
         end else if (handshake_s) begin
            order_valid <= 1'b0;
            order_qty   <= 8'd0;
            // The limit check at accept time guarantees these never wrap.
            if (order_side == SIDE_SELL) begin
               position <= pos_minus_s[POS_W-1:0];
            end else begin
               position <= pos_plus_s[POS_W-1:0];
            end
         end else begin
            order_valid <= order_valid;
         end
      end
   end

`ifdef ORDER_STATS_EN
   logic drop_s;

   // Any buy/sell request that does not become an order counts as a drop.
   always_comb begin
      drop_s = signal_valid & (buy_signal | sell_signal) & ~accept_s;
   end

   // Saturating order statistics.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         buy_count  <= 16'd0;
         sell_count <= 16'd0;
         drop_count <= 16'd0;
      end else begin
         if (handshake_s && (order_side == SIDE_BUY)) begin
            buy_count <= sat_inc16(buy_count);
         end
         if (handshake_s && (order_side == SIDE_SELL)) begin
            sell_count <= sat_inc16(sell_count);
         end
         if (drop_s) begin
            drop_count <= sat_inc16(drop_count);
         end
      end
   end
`endif

endmodule
